dma_line_ctrl: RTL and testbench

//  Sequencer for the DMA 64->256-bit line packer. Accepts a transfer descriptor
//  (SDRAM source, on-chip memory destination, line count), issues 64-bit SDRAM

---
 rtl/dma_line_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_dma_line_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_line_ctrl.sv
// ---------------------------------------------------------------------------
// dma_line_ctrl
//   Sequencer for the DMA 64->256-bit line packer. A descriptor (SDRAM source
//   word address, on-chip memory destination line address, line count) is
//   accepted in IDLE. For every line the packer is cleared, BEATS_PER_LINE
//   64-bit SDRAM beats are fetched into it, the assembled line is drained and
//   written to on-chip memory. A one-cycle done pulse ends the transfer.
//
// Ports
//   clk_h, rst_n          clock, synchronous active-low reset
//   start, abort          descriptor valid (IDLE only) / cancel transfer
//   src_addr, dst_addr    first SDRAM word / first memory line address
//   line_count            number of 256-bit lines (0 -> immediate done)
//   busy, done, err       status: non-IDLE, completion pulse, sticky timeout
//   sdram_rd_req/addr     SDRAM read request and word address
//   sdram_rd_ack          SDRAM beat accepted, data valid this cycle
//   clear_data            packer clear pulse
//   sdram_read_enable     packer capture enable (FETCH)
//   add_sdram_addr        packer beat strobe (req & ack)
//   empty_buffer          packer drain pulse
//   write_ready           packer holds a full line
//   read_ready            packer may accept beats
//   mem_we, mem_addr      on-chip memory line write strobe and address
// ---------------------------------------------------------------------------
module dma_line_ctrl #(
  parameter int SDRAM_AW       = 24,
  parameter int MEM_AW         = 12,
  parameter int LEN_W          = 12,
  parameter int BEATS_PER_LINE = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                clk_h,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [SDRAM_AW-1:0] src_addr,
  input  logic [MEM_AW-1:0]   dst_addr,
  input  logic [LEN_W-1:0]    line_count,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                sdram_rd_req,
  output logic [SDRAM_AW-1:0] sdram_addr,
  input  logic                sdram_rd_ack,
  output logic                clear_data,
  output logic                sdram_read_enable,
  output logic                add_sdram_addr,
  output logic                empty_buffer,
  input  logic                write_ready,
  input  logic                read_ready,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr
);

  localparam int BEAT_W = $clog2(BEATS_PER_LINE + 1);
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] BEAT_FULL = BEAT_W'(BEATS_PER_LINE);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS_PER_LINE - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_DRAIN = 3'd4,
    S_WRITE = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [SDRAM_AW-1:0] sdram_addr_r;
  logic [MEM_AW-1:0]   mem_addr_r;
  logic [LEN_W-1:0]    lines_left_r;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic [WD_W-1:0]     wdog_r;
  logic                err_r;
  logic                clear_pend_r;

  logic                req_s;
  logic                beat_s;
  logic                abort_s;
  logic                timeout_s;
  logic                accept_s;

  // A beat counts only when a request is outstanding; a bare ack is ignored.
  assign req_s     = (state_r == S_FETCH) && read_ready && (beat_cnt_r < BEAT_FULL);
  assign beat_s    = req_s && sdram_rd_ack;
  assign abort_s   = abort && (state_r != S_IDLE);
  assign timeout_s = (state_r == S_WAIT) && !write_ready && (wdog_r == WD_LIMIT);
  assign accept_s  = (state_r == S_IDLE) && start;

  assign busy              = (state_r != S_IDLE);
  assign done              = (state_r == S_DONE);
  assign err               = err_r;
  assign sdram_rd_req      = req_s;
  assign sdram_addr        = sdram_addr_r;
  // Packer is cleared at the start of each line and again after an abort or
  // timeout so no partial line survives into the next transfer.
  assign clear_data        = (state_r == S_CLEAR) || clear_pend_r;
  assign sdram_read_enable = (state_r == S_FETCH);
  assign add_sdram_addr    = beat_s;
  assign empty_buffer      = (state_r == S_DRAIN);
  assign mem_we            = (state_r == S_WRITE);
  assign mem_addr          = mem_addr_r;

  // State register.
  always_ff @(posedge clk_h) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = (line_count != {LEN_W{1'b0}}) ? S_CLEAR : S_DONE;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_CLEAR: next_state_s = S_FETCH;
      S_FETCH: begin
        if (beat_s && (beat_cnt_r == BEAT_LAST)) begin
          next_state_s = S_WAIT;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_WAIT: begin
        if (write_ready) begin
          next_state_s = S_DRAIN;
        end else if (timeout_s) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_WAIT;
        end
      end
      S_DRAIN: next_state_s = S_WRITE;
      S_WRITE: begin
        if (lines_left_r == LEN_W'(1)) begin
          next_state_s = S_DONE;
        end else begin
          next_state_s = S_CLEAR;
        end
      end
      S_DONE:  next_state_s = S_IDLE;
      default: next_state_s = S_IDLE;
    endcase
    if (abort_s) begin
      next_state_s = S_IDLE;
    end else begin
      next_state_s = next_state_s;
    end
  end

  // Addresses, counters, watchdog and status flags.
  always_ff @(posedge clk_h) begin
    if (!rst_n) begin
      sdram_addr_r <= {SDRAM_AW{1'b0}};
      mem_addr_r   <= {MEM_AW{1'b0}};
      lines_left_r <= {LEN_W{1'b0}};
      beat_cnt_r   <= {BEAT_W{1'b0}};
      wdog_r       <= {WD_W{1'b0}};
      err_r        <= 1'b0;
      clear_pend_r <= 1'b0;
    end else begin
      clear_pend_r <= abort_s || timeout_s;
      if (accept_s) begin
        err_r <= 1'b0;
      end else if (timeout_s && !abort) begin
        err_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (start && (line_count != {LEN_W{1'b0}})) begin
            sdram_addr_r <= src_addr;
            mem_addr_r   <= dst_addr;
            lines_left_r <= line_count;
          end
        end
        S_CLEAR: begin
          beat_cnt_r <= {BEAT_W{1'b0}};
          wdog_r     <= {WD_W{1'b0}};
        end
        S_FETCH: begin
          if (beat_s) begin
            sdram_addr_r <= sdram_addr_r + SDRAM_AW'(1);
            beat_cnt_r   <= beat_cnt_r + BEAT_W'(1);
          end
        end
        S_WAIT: begin
          wdog_r <= wdog_r + WD_W'(1);
        end
        S_WRITE: begin
          mem_addr_r   <= mem_addr_r + MEM_AW'(1);
          lines_left_r <= lines_left_r - LEN_W'(1);
        end
        default: begin
          beat_cnt_r <= beat_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_line_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dma_line_ctrl
//   Directed bench for dma_line_ctrl. A responder emulates SDRAM acks and
//   the packer's write_ready; a monitor checks every cycle against expected
//   beat/line address queues computed arithmetically from each descriptor.
// ---------------------------------------------------------------------------
module tb_dma_line_ctrl;

  localparam int SAW = 24;
  localparam int MAW = 12;
  localparam int LW  = 12;
  localparam int BPL = 4;
  localparam int TO  = 255;

  logic           clk_h = 1'b0;
  logic           rst_n;
  logic           start, abort;
  logic [SAW-1:0] src_addr;
  logic [MAW-1:0] dst_addr;
  logic [LW-1:0]  line_count;
  logic           busy, done, err, sdram_rd_req, sdram_rd_ack;
  logic [SAW-1:0] sdram_addr;
  logic           clear_data, sdram_read_enable, add_sdram_addr, empty_buffer;
  logic           write_ready, read_ready, mem_we;
  logic [MAW-1:0] mem_addr;

  always #5 clk_h = ~clk_h;

  dma_line_ctrl #(
    .SDRAM_AW(SAW), .MEM_AW(MAW), .LEN_W(LW), .BEATS_PER_LINE(BPL), .TIMEOUT(TO)
  ) dut (
    .clk_h(clk_h), .rst_n(rst_n), .start(start), .abort(abort),
    .src_addr(src_addr), .dst_addr(dst_addr), .line_count(line_count),
    .busy(busy), .done(done), .err(err),
    .sdram_rd_req(sdram_rd_req), .sdram_addr(sdram_addr), .sdram_rd_ack(sdram_rd_ack),
    .clear_data(clear_data), .sdram_read_enable(sdram_read_enable),
    .add_sdram_addr(add_sdram_addr), .empty_buffer(empty_buffer),
    .write_ready(write_ready), .read_ready(read_ready),
    .mem_we(mem_we), .mem_addr(mem_addr)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Expected beat and line addresses, in issue order.
  logic [SAW-1:0] exp_beat_q[$];
  logic [MAW-1:0] exp_mem_q[$];

  int n_strobe, n_mem, n_clear, n_empty, n_done, n_req;
  int beats_line, fcnt, last_done_cyc, start_cyc;
  int ack_mode, wr_mode;
  logic [SAW-1:0] first_strobe_addr, last_strobe_addr;
  logic [MAW-1:0] last_mem_addr;
  logic done_err, done_clear;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk_h) cyc <= cyc + 1;

  // Responder (at negedge) and per-cycle monitor (2ns later).
  always @(negedge clk_h) begin
    if (sdram_read_enable) begin
      sdram_rd_ack = (ack_mode == 0) ? 1'b1 : ((fcnt % 3) == 2);
      fcnt++;
    end else begin
      sdram_rd_ack = 1'b0;
      fcnt = 0;
    end
    write_ready = (wr_mode != 0) && (beats_line == BPL);
    #2;
    chk("strobe_is_req_and_ack", add_sdram_addr, sdram_rd_req & sdram_rd_ack);
    if (!read_ready) chk("req_low_without_read_ready", sdram_rd_req, 1'b0);
    if (sdram_rd_req) n_req++;
    if (add_sdram_addr) begin
      if (n_strobe == 0) first_strobe_addr = sdram_addr;
      n_strobe++;
      beats_line++;
      last_strobe_addr = sdram_addr;
      if (exp_beat_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_beat actual_addr=0x%0h required=none", sdram_addr);
      end else begin
        chk("beat_addr", sdram_addr, exp_beat_q.pop_front());
      end
    end
    if (mem_we) begin
      n_mem++;
      last_mem_addr = mem_addr;
      if (exp_mem_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_mem_we actual_addr=0x%0h required=none", mem_addr);
      end else begin
        chk("mem_addr", mem_addr, exp_mem_q.pop_front());
      end
    end
    if (clear_data) begin n_clear++; beats_line = 0; end
    if (empty_buffer) begin n_empty++; beats_line = 0; end
    if (!busy) beats_line = 0;
    if (done) begin
      n_done++;
      last_done_cyc = cyc;
      done_err = err;
      done_clear = clear_data;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_h);
      #1;
    end
  endtask

  task automatic clear_stats();
    n_strobe = 0; n_mem = 0; n_clear = 0; n_empty = 0; n_done = 0; n_req = 0;
    exp_beat_q.delete();
    exp_mem_q.delete();
  endtask

  // Pulse start for one cycle and record what the descriptor must produce.
  task automatic run_xfer(input logic [SAW-1:0] s, input logic [MAW-1:0] d,
                          input int n, input bit expect_write);
    logic [SAW-1:0] a;
    logic [MAW-1:0] m;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < BPL; i++) begin
        a = s + SAW'(k * BPL + i);
        exp_beat_q.push_back(a);
      end
      m = d + MAW'(k);
      if (expect_write) exp_mem_q.push_back(m);
    end
    src_addr = s; dst_addr = d; line_count = LW'(n);
    start = 1'b1;
    start_cyc = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    for (int i = 0; i < bound && n_done == 0; i++) step(1);
    chk({name, "_done_seen"}, (n_done != 0), 1'b1);
  endtask

  task automatic check_quiet(input string name);
    chk({name, "_flags"}, {busy, done, err, sdram_rd_req, sdram_read_enable,
        add_sdram_addr, clear_data, empty_buffer, mem_we}, 9'h000);
    chk({name, "_sdram_addr"}, sdram_addr, 24'h000000);
    chk({name, "_mem_addr"}, mem_addr, 12'h000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; line_count = '0;
    read_ready = 1'b1; sdram_rd_ack = 1'b0; write_ready = 1'b0;
    ack_mode = 0; wr_mode = 1; beats_line = 0; fcnt = 0;
    last_done_cyc = 0; start_cyc = 0;
    clear_stats();
    step(2);
    check_quiet("reset");
    rst_n = 1'b1;
    step(1);

    // T2: one line, back-to-back acks.
    clear_stats();
    run_xfer(24'h000100, 12'h010, 1, 1'b1);
    wait_done("t2", 50);
    step(2);
    chk("t2_latency", last_done_cyc - start_cyc, 32'd9);
    chk("t2_first_beat", first_strobe_addr, 24'h000100);
    chk("t2_last_beat", last_strobe_addr, 24'h000103);
    chk("t2_beats", n_strobe, 32'd4);
    chk("t2_drains", n_empty, 32'd1);
    chk("t2_mem_we", n_mem, 32'd1);
    chk("t2_mem_addr", last_mem_addr, 12'h010);
    chk("t2_clears", n_clear, 32'd1);
    chk("t2_beats_left", exp_beat_q.size(), 32'd0);

    // T3: three lines, two stall cycles per beat; a start mid-transfer is ignored.
    clear_stats();
    ack_mode = 1;
    run_xfer(24'h000100, 12'h010, 3, 1'b1);
    step(3);
    src_addr = 24'h000999; dst_addr = 12'h099; line_count = 12'd5;
    start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done("t3", 300);
    step(3);
    ack_mode = 0;
    chk("t3_beats", n_strobe, 32'd12);
    chk("t3_last_beat", last_strobe_addr, 24'h00010B);
    chk("t3_clears", n_clear, 32'd3);
    chk("t3_mem_we", n_mem, 32'd3);
    chk("t3_last_mem", last_mem_addr, 12'h012);
    chk("t3_one_done", n_done, 32'd1);
    chk("t3_idle", busy, 1'b0);

    // T4: zero lines, with abort in the same cycle (abort must be ignored).
    clear_stats();
    abort = 1'b1;
    run_xfer(24'h000500, 12'h050, 0, 1'b1);
    abort = 1'b0;
    wait_done("t4", 10);
    step(2);
    chk("t4_latency", last_done_cyc - start_cyc, 32'd1);
    chk("t4_no_req", n_req, 32'd0);
    chk("t4_no_mem_we", n_mem, 32'd0);
    chk("t4_err", done_err, 1'b0);

    // T5: write_ready never rises -> watchdog timeout.
    clear_stats();
    wr_mode = 0;
    run_xfer(24'h000300, 12'h040, 1, 1'b0);
    wait_done("t5", 400);
    step(2);
    wr_mode = 1;
    chk("t5_latency", last_done_cyc - start_cyc, 32'd262);
    chk("t5_err_at_done", done_err, 1'b1);
    chk("t5_clear_at_done", done_clear, 1'b1);
    chk("t5_clears", n_clear, 32'd2);
    chk("t5_no_mem_we", n_mem, 32'd0);
    chk("t5_err_sticky", err, 1'b1);
    clear_stats();
    run_xfer(24'h000300, 12'h040, 1, 1'b1);
    chk("t5_err_cleared", err, 1'b0);
    wait_done("t5b", 50);
    step(2);
    chk("t5b_mem_we", n_mem, 32'd1);

    // T6: address wrap, read_ready stall, abort during the third beat.
    clear_stats();
    run_xfer(24'hFFFFFE, 12'h020, 1, 1'b1);
    for (int i = 0; i < 20 && n_strobe < 2; i++) step(1);
    read_ready = 1'b0;
    step(1);
    chk("t6_req_drop", sdram_rd_req, 1'b0);
    chk("t6_still_fetch", sdram_read_enable, 1'b1);
    step(2);
    read_ready = 1'b1;
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t6_abort_idle", busy, 1'b0);
    chk("t6_abort_clear", clear_data, 1'b1);
    step(3);
    chk("t6_beats", n_strobe, 32'd3);
    chk("t6_wrap_addr", last_strobe_addr, 24'h000000);
    chk("t6_no_done", n_done, 32'd0);
    chk("t6_no_mem_we", n_mem, 32'd0);
    chk("t6_clears", n_clear, 32'd2);
    chk("t6_err", err, 1'b0);
    clear_stats();
    run_xfer(24'h000040, 12'h030, 1, 1'b1);
    wait_done("t6_restart", 50);
    step(2);
    chk("t6_restart_mem_we", n_mem, 32'd1);
    chk("t6_restart_beats", n_strobe, 32'd4);

    // T1: synchronous reset in the middle of FETCH.
    clear_stats();
    run_xfer(24'h000200, 12'h005, 2, 1'b1);
    for (int i = 0; i < 20 && n_strobe < 1; i++) step(1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_quiet("t1_reset");
    step(15);
    chk("t1_no_done", n_done, 32'd0);
    chk("t1_idle", busy, 1'b0);
    chk("t1_no_mem_we", n_mem, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
